// File: rtl/rp_acq_pkg.sv
// Shared acquisition-path constants and helpers used by the decimation stage.
// Holds the decimation-factor width, the accumulator sizing and the shift-amount encoder.
package rp_acq_pkg;

    localparam int DEC_W   = 17;
    localparam int DEC_MAX = 65536;
    localparam int SHIFT_W = 5;

    // Accumulator wide enough to sum DEC_MAX full-scale samples without wrapping.
    function automatic int acc_width(input int dw, input int decw);
        return dw + decw;
    endfunction

    // Priority encoder: index of the highest set bit, i.e. log2 of a power of two.
    function automatic logic [SHIFT_W-1:0] pow2_log2(input logic [31:0] n);
        logic [SHIFT_W-1:0] idx;
        idx = 5'd0;
        for (int i = 0; i < 32; i++) begin
            if (n[i]) begin
                idx = SHIFT_W'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rp_dec_cfg_latch.sv
// Per-block configuration latch for the decimator: sanitises N, detects powers of two,
// derives the averaging shift and drives the N==1 indicator.
module rp_dec_cfg_latch
    import rp_acq_pkg::*;
#(
    parameter int DECW = DEC_W
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_load,
    input  logic [DECW-1:0]     i_dec,
    input  logic                i_avg,
    output logic [DECW-1:0]     o_n_eff,
    output logic                o_avg,
    output logic                o_pow2,
    output logic [SHIFT_W-1:0]  o_shift,
    output logic                o_dec1
);

    logic [DECW-1:0]    w_n_san;
    logic               w_pow2;
    logic [SHIFT_W-1:0] w_shift;
    logic [DECW-1:0]    r_n;
    logic               r_avg;
    logic               r_pow2;
    logic [SHIFT_W-1:0] r_shift;
    logic               r_dec1;

    // Sanitise N and precompute block parameters; the block-start sample sees the new N directly.
    always_comb begin
        w_n_san = i_dec;
        if (i_dec == {DECW{1'b0}}) begin
            w_n_san = DECW'(1);
        end else begin
            w_n_san = i_dec;
        end
        w_pow2  = ((w_n_san & (w_n_san - DECW'(1))) == {DECW{1'b0}});
        w_shift = pow2_log2(32'(w_n_san));
        if (i_load) begin
            o_n_eff = w_n_san;
        end else begin
            o_n_eff = r_n;
        end
    end

    // Configuration registers, captured only at block start.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_n     <= DECW'(1);
            r_avg   <= 1'b0;
            r_pow2  <= 1'b1;
            r_shift <= 5'd0;
            r_dec1  <= 1'b1;
        end else if (i_load) begin
            r_n     <= w_n_san;
            r_avg   <= i_avg;
            r_pow2  <= w_pow2;
            r_shift <= w_shift;
            r_dec1  <= (w_n_san == DECW'(1));
        end else begin
            r_n     <= r_n;
            r_avg   <= r_avg;
            r_pow2  <= r_pow2;
            r_shift <= r_shift;
            r_dec1  <= r_dec1;
        end
    end

    assign o_avg   = r_avg;
    assign o_pow2  = r_pow2;
    assign o_shift = r_shift;
    assign o_dec1  = r_dec1;

endmodule

// File: rtl/rp_adc_dec_avg.sv
// Decimating boxcar averager for one ADC channel: one output per N accepted samples,
// either the block mean (power-of-two N) or the last sample, two cycles after block end.
module rp_adc_dec_avg
    import rp_acq_pkg::*;
#(
    parameter int DW   = 14,
    parameter int DECW = DEC_W
) (
    input  logic                 adc_clk_i,
    input  logic                 adc_rstn_i,
    input  logic signed [DW-1:0] adc_dat_i,
    input  logic                 adc_dv_i,
    input  logic [DECW-1:0]      set_dec_i,
    input  logic                 set_avg_en_i,
    input  logic                 dec_clr_i,
    output logic signed [DW-1:0] dec_dat_o,
    output logic                 dec_dv_o,
    output logic                 dec1_o
);

    localparam int AW = acc_width(DW, DECW);

    logic                 w_accept;
    logic                 w_start;
    logic                 w_end;
    logic [DECW-1:0]      w_n_eff;
    logic                 w_avg_l;
    logic                 w_pow2_l;
    logic [SHIFT_W-1:0]   w_shift_l;
    logic signed [AW-1:0] w_smp_x;
    logic signed [AW-1:0] w_acc_nxt;
    logic signed [DW-1:0] w_sel;

    logic [DECW-1:0]      r_cnt;
    logic signed [AW-1:0] r_acc;
    logic signed [AW-1:0] r_sum;
    logic signed [DW-1:0] r_last;
    logic                 r_s1_vld;
    logic signed [DW-1:0] r_dat;
    logic                 r_dv;

    rp_dec_cfg_latch #(
        .DECW (DECW)
    ) u_cfg (
        .i_clk   (adc_clk_i),
        .i_rst_n (adc_rstn_i),
        .i_load  (w_start),
        .i_dec   (set_dec_i),
        .i_avg   (set_avg_en_i),
        .o_n_eff (w_n_eff),
        .o_avg   (w_avg_l),
        .o_pow2  (w_pow2_l),
        .o_shift (w_shift_l),
        .o_dec1  (dec1_o)
    );

    // Sample acceptance, block boundaries, running sum and output selection.
    always_comb begin
        w_accept = adc_dv_i & ~dec_clr_i;
        w_start  = w_accept & (r_cnt == {DECW{1'b0}});
        w_end    = w_accept & (r_cnt == (w_n_eff - DECW'(1)));
        w_smp_x  = AW'(adc_dat_i);
        if (r_cnt == {DECW{1'b0}}) begin
            w_acc_nxt = w_smp_x;
        end else begin
            w_acc_nxt = r_acc + w_smp_x;
        end
        // Floor-rounded mean; the shifted value always fits back into DW bits.
        if (w_avg_l && w_pow2_l) begin
            w_sel = DW'(r_sum >>> w_shift_l);
        end else begin
            w_sel = r_last;
        end
    end

    // Counter, accumulator and first pipeline stage; clear discards the partial block.
    always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
        if (!adc_rstn_i) begin
            r_cnt    <= {DECW{1'b0}};
            r_acc    <= {AW{1'b0}};
            r_sum    <= {AW{1'b0}};
            r_last   <= {DW{1'b0}};
            r_s1_vld <= 1'b0;
        end else if (dec_clr_i) begin
            r_cnt    <= {DECW{1'b0}};
            r_acc    <= {AW{1'b0}};
            r_s1_vld <= 1'b0;
        end else begin
            r_s1_vld <= w_end;
            if (w_accept) begin
                r_acc <= w_acc_nxt;
                if (w_end) begin
                    r_cnt  <= {DECW{1'b0}};
                    r_sum  <= w_acc_nxt;
                    r_last <= adc_dat_i;
                end else begin
                    r_cnt  <= r_cnt + DECW'(1);
                end
            end else begin
                r_cnt <= r_cnt;
                r_acc <= r_acc;
            end
        end
    end

    // Output stage: pulse for one cycle and hold the data until the next block.
    always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
        if (!adc_rstn_i) begin
            r_dat <= {DW{1'b0}};
            r_dv  <= 1'b0;
        end else if (dec_clr_i) begin
            r_dv  <= 1'b0;
        end else begin
            r_dv <= r_s1_vld;
            if (r_s1_vld) begin
                r_dat <= w_sel;
            end else begin
                r_dat <= r_dat;
            end
        end
    end

    assign dec_dat_o = r_dat;
    assign dec_dv_o  = r_dv;

endmodule

// File: doc/rp_adc_dec_avg.md
# rp_adc_dec_avg

Decimation and boxcar-averaging stage that sits directly upstream of the AXI acquisition state machine. It consumes one signed ADC channel at full rate and emits one decimated, optionally averaged, sample per N accepted inputs. Its outputs drive the state machine's sample data, sample-valid and decimation-is-one inputs. One instance is built per channel.

## Interface
Parameters:
- DW, 14, sample width (signed, two's complement) on input and output.
- DECW, 17, width of the decimation factor; N max = 2^(DECW-1) = 65536.

Ports:
- adc_clk_i  in  1  ADC clock; single clock domain.
- adc_rstn_i  in  1  asynchronous, active-low reset.
- adc_dat_i  in  DW  signed input sample.
- adc_dv_i  in  1  input sample valid; a sample is accepted on a cycle with adc_dv_i=1.
- set_dec_i  in  DECW  decimation factor N; 0 is treated as 1.
- set_avg_en_i  in  1  1 = average over the block; 0 = take the last sample of the block.
- dec_clr_i  in  1  synchronous restart (arm/reset pulse); discards the partial block.
- dec_dat_o  out  DW  signed decimated sample.
- dec_dv_o  out  1  single-cycle pulse, one per completed block.
- dec1_o  out  1  high while the latched N equals 1; drives set_dec1_i downstream.

## Operation
- State: sample counter cnt (DECW bits), accumulator acc (DW+DECW bits, signed), latched config (n_l, avg_l, pow2_l, shift_l), and a pipeline register stage.
- Block start (cnt==0 on an accepted sample, or after clear/reset):
  - latch n_l = max(set_dec_i, 1) and avg_l = set_avg_en_i;
  - compute pow2_l = ((n_l & (n_l-1)) == 0) and shift_l = log2(n_l) using a priority encoder.
  - Config changes mid-block have no effect until the next block.
- Each accepted sample:
  - acc <= (cnt==0 ? sext(adc_dat_i) : acc + sext(adc_dat_i));
  - cnt <= (cnt == n_l-1) ? 0 : cnt+1.
- Block end (accepted sample with cnt==n_l-1): stage 1 registers sum = acc + sample, last = sample and a flag.
- Stage 2 output selection:
  - avg_l=1 and pow2_l=1: dec_dat_o = sum >>> shift_l (arithmetic shift, floor rounding);
  - otherwise (avg disabled, or N not a power of two): dec_dat_o = last. Averaging for non-power-of-two N is not supported.
- Arithmetic: the accumulator never overflows, since DW+DECW bits hold 65536 × full-scale. The output is truncated to DW bits after the shift, which is exact because the result lies in the input range.
- N=1: every accepted sample produces an output through the same 2-stage pipeline. Average and last are identical in this case.
- dec_clr_i:
  - cnt <= 0, acc <= 0, pipeline flags cleared;
  - a dec_dv_o that would have fired on the next or second-next cycle is suppressed;
  - config is re-latched on the next accepted sample.
  - Clear and sample in the same cycle: clear wins and the sample is discarded.
- Reset values: dec_dat_o=0, dec_dv_o=0, dec1_o=1 (n_l resets to 1), cnt=0, acc=0.
- Reset mid-block: all state returns to the reset values asynchronously; no partial output is emitted.

## Timing
- Latency: block-ending sample accepted at cycle t -> dec_dv_o=1 and dec_dat_o valid at cycle t+2.
- dec_dat_o holds its value until the next dec_dv_o.
- dec_dv_o is high for exactly 1 cycle per block.
- Maximum output rate is 1 per cycle (N=1 with adc_dv_i held high).
- There is no backpressure: the downstream stage must accept every pulse.
- dec1_o updates 1 cycle after the block-start sample that latches a new N.
- Gaps in adc_dv_i stall cnt and acc but not the pipeline. An in-flight output still appears at t+2 regardless of later adc_dv_i.

## Structure
- Shared package rp_acq_pkg:
  - constants DEC_W=17 and DEC_MAX=65536;
  - function for the log2/priority encode of a power of two;
  - accumulator width expression DW+DEC_W.
- Natural sub-module: rp_dec_cfg_latch, which holds the latched config (N sanitising, pow2 detection, shift computation, dec1_o). The counter, accumulator and output pipeline stay in the top.
- Target size: roughly 150–250 lines of RTL.

## Test plan
- N=4, avg=1, inputs 10,20,30,41 -> one pulse at t+2 with dec_dat_o=25 (101>>>2 = 25); no other pulses.
- N=8, avg=1, inputs all -8192 (DW=14 full negative scale) -> dec_dat_o=-8192; N=65536 with all 8191 -> 8191, accumulator does not overflow.
- N=3, avg=1, inputs 5,6,7 -> dec_dat_o=7 (last sample, non-power-of-two); N=1 with a ramp 0..9 -> 10 pulses on consecutive cycles with the values delayed by 2, dec1_o=1.
- N=4: set_dec_i changed to 2 after the 2nd sample of a block -> the current block completes after 4 samples, the next after 2; dec1_o stays 0.
- dec_clr_i asserted on the same cycle as the block-ending sample -> no pulse; the next 4 samples give a clean average. Toggle adc_dv_i 1-of-3 -> output values are unchanged, only their spacing changes.
- Assert adc_rstn_i low mid-block and while a pulse is in flight -> dec_dv_o=0 and dec_dat_o=0 immediately; after release the first output appears only after a full N samples.
